// File: rtl/sw_scoring_ctrl.sv
// Sequencing controller in front of the Smith-Waterman scoring array.
//
// A configuration request loads the penalties and the query into the array, then waits
// PREG_NUM cycles for the penalty registers to ripple through. In RUN it interleaves two
// independent target-base streams onto the array's single base input: lane k may only
// transfer while the array's toggle phase equals k. Each lane's final score is captured
// on the array's valid pulse, or replaced by an error if the pulse never arrives. The
// score is then held for a ready/valid consumer.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cfg_start, cfg_*                configuration request and fields; cfg_busy status
//   tk_valid/tk_last/tk_base/tk_ready   lane k target-base stream (k = 0, 1)
//   resk_valid/resk_data/resk_err/resk_ready   lane k score output
//   sm_ld_p, sm_ld_q, sm_match..sm_output_select   registered configuration to the array
//   sm_data_in, sm_en0, sm_en1      base and lane enables to the array
//   sm_toggle, sm_vld0/1, sm_result0/1   array phase and results
module sw_scoring_ctrl #(
    parameter int unsigned SCORE_WIDTH = 12,
    parameter int unsigned LENGTH      = 128,
    parameter int unsigned ADDR_WIDTH  = $clog2(LENGTH) + 1,
    parameter int unsigned PREG_FREQ   = 8,
    parameter int unsigned PREG_NUM    = LENGTH / PREG_FREQ,
    parameter int unsigned TIMEOUT     = 2 * LENGTH + 8
) (
    input  logic                   clk,
    input  logic                   rst,
    // configuration
    input  logic                   cfg_start,
    input  logic [SCORE_WIDTH-1:0] cfg_match,
    input  logic [SCORE_WIDTH-1:0] cfg_mismatch,
    input  logic [SCORE_WIDTH-1:0] cfg_gap_open,
    input  logic [SCORE_WIDTH-1:0] cfg_gap_extend,
    input  logic [2*LENGTH-1:0]    cfg_query,
    input  logic [ADDR_WIDTH-1:0]  cfg_qlen,
    output logic                   cfg_busy,
    // lane 0 target stream
    input  logic                   t0_valid,
    input  logic                   t0_last,
    input  logic [1:0]             t0_base,
    output logic                   t0_ready,
    // lane 1 target stream
    input  logic                   t1_valid,
    input  logic                   t1_last,
    input  logic [1:0]             t1_base,
    output logic                   t1_ready,
    // lane 0 result
    output logic                   res0_valid,
    output logic [SCORE_WIDTH-1:0] res0_data,
    output logic                   res0_err,
    input  logic                   res0_ready,
    // lane 1 result
    output logic                   res1_valid,
    output logic [SCORE_WIDTH-1:0] res1_data,
    output logic                   res1_err,
    input  logic                   res1_ready,
    // scoring array side
    output logic                   sm_ld_p,
    output logic                   sm_ld_q,
    output logic [SCORE_WIDTH-1:0] sm_match,
    output logic [SCORE_WIDTH-1:0] sm_mismatch,
    output logic [SCORE_WIDTH-1:0] sm_gap_open,
    output logic [SCORE_WIDTH-1:0] sm_gap_extend,
    output logic [2*LENGTH-1:0]    sm_query,
    output logic [ADDR_WIDTH-1:0]  sm_output_select,
    output logic [1:0]             sm_data_in,
    output logic                   sm_en0,
    output logic                   sm_en1,
    input  logic                   sm_toggle,
    input  logic                   sm_vld0,
    input  logic                   sm_vld1,
    input  logic [SCORE_WIDTH-1:0] sm_result0,
    input  logic [SCORE_WIDTH-1:0] sm_result1
);

    localparam int unsigned PW = (PREG_NUM > 1) ? $clog2(PREG_NUM) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StLoadP, StLoadQ, StProp, StRun} top_state_e;
    typedef enum logic [1:0] {LIdle, LFeed, LWait, LHold} lane_state_e;

    top_state_e             top_q, top_d;
    logic [PW-1:0]          prop_cnt_q, prop_cnt_d;
    logic                   cfg_accept;

    logic                   ld_p_q, ld_q_q;
    logic [SCORE_WIDTH-1:0] match_q, mismatch_q, gap_open_q, gap_extend_q;
    logic [2*LENGTH-1:0]    query_q;
    logic [ADDR_WIDTH-1:0]  out_sel_q;

    lane_state_e            lane_q [2];
    lane_state_e            lane_d [2];
    logic [TW-1:0]          timer_q [2];
    logic [TW-1:0]          timer_d [2];
    logic                   res_valid_q [2];
    logic                   res_valid_d [2];
    logic                   res_err_q [2];
    logic                   res_err_d [2];
    logic [SCORE_WIDTH-1:0] res_data_q [2];
    logic [SCORE_WIDTH-1:0] res_data_d [2];

    logic                   lane_valid [2];
    logic                   lane_last [2];
    logic                   lane_ready [2];
    logic                   lane_xfer [2];
    logic                   lane_vld [2];
    logic                   lane_res_ready [2];
    logic [SCORE_WIDTH-1:0] lane_result [2];

    assign lane_valid[0]     = t0_valid;
    assign lane_valid[1]     = t1_valid;
    assign lane_last[0]      = t0_last;
    assign lane_last[1]      = t1_last;
    assign lane_vld[0]       = sm_vld0;
    assign lane_vld[1]       = sm_vld1;
    assign lane_res_ready[0] = res0_ready;
    assign lane_res_ready[1] = res1_ready;
    assign lane_result[0]    = sm_result0;
    assign lane_result[1]    = sm_result1;

    // Busy covers the load/propagate window and any lane holding a sequence, so the array
    // configuration can never change underneath an in-flight alignment.
    assign cfg_busy = (top_q == StLoadP) || (top_q == StLoadQ) || (top_q == StProp) ||
                      (lane_q[0] != LIdle) || (lane_q[1] != LIdle);

    // ---------------- top FSM ----------------
    always_comb begin
        top_d      = top_q;
        prop_cnt_d = prop_cnt_q;
        cfg_accept = 1'b0;
        unique case (top_q)
            StIdle, StRun: begin
                if (cfg_start && !cfg_busy) begin
                    cfg_accept = 1'b1;
                    top_d      = StLoadP;
                end
            end
            StLoadP: top_d = StLoadQ;
            StLoadQ: begin
                top_d      = StProp;
                prop_cnt_d = PW'(PREG_NUM - 1);
            end
            StProp: begin
                if (prop_cnt_q == '0) begin
                    top_d = StRun;
                end else begin
                    prop_cnt_d = prop_cnt_q - 1'b1;
                end
            end
            default: top_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q        <= StIdle;
            prop_cnt_q   <= '0;
            ld_p_q       <= 1'b0;
            ld_q_q       <= 1'b0;
            match_q      <= '0;
            mismatch_q   <= '0;
            gap_open_q   <= '0;
            gap_extend_q <= '0;
            query_q      <= '0;
            out_sel_q    <= '0;
        end else begin
            top_q      <= top_d;
            prop_cnt_q <= prop_cnt_d;
            ld_p_q     <= cfg_accept;
            ld_q_q     <= (top_q == StLoadP);
            if (cfg_accept) begin
                match_q      <= cfg_match;
                mismatch_q   <= cfg_mismatch;
                gap_open_q   <= cfg_gap_open;
                gap_extend_q <= cfg_gap_extend;
                query_q      <= cfg_query;
                out_sel_q    <= cfg_qlen;
            end
        end
    end

    // ---------------- lane FSMs ----------------
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            lane_d[k]      = lane_q[k];
            timer_d[k]     = timer_q[k];
            res_valid_d[k] = res_valid_q[k];
            res_err_d[k]   = res_err_q[k];
            res_data_d[k]  = res_data_q[k];

            // A lane only owns the array input in its own toggle phase.
            lane_ready[k] = (top_q == StRun) &&
                            ((lane_q[k] == LIdle) || (lane_q[k] == LFeed)) &&
                            (sm_toggle == 1'(k));
            lane_xfer[k]  = lane_valid[k] && lane_ready[k];

            unique case (lane_q[k])
                LIdle, LFeed: begin
                    if (lane_xfer[k]) begin
                        if (lane_last[k]) begin
                            lane_d[k]  = LWait;
                            timer_d[k] = TW'(TIMEOUT);
                        end else begin
                            lane_d[k] = LFeed;
                        end
                    end
                end
                LWait: begin
                    if (lane_vld[k]) begin
                        lane_d[k]      = LHold;
                        res_valid_d[k] = 1'b1;
                        res_err_d[k]   = 1'b0;
                        res_data_d[k]  = lane_result[k];
                    end else if (timer_q[k] == '0) begin
                        lane_d[k]      = LHold;
                        res_valid_d[k] = 1'b1;
                        res_err_d[k]   = 1'b1;
                        res_data_d[k]  = '0;
                    end else begin
                        timer_d[k] = timer_q[k] - 1'b1;
                    end
                end
                LHold: begin
                    if (lane_res_ready[k]) begin
                        lane_d[k]      = LIdle;
                        res_valid_d[k] = 1'b0;
                        res_err_d[k]   = 1'b0;
                    end
                end
                default: lane_d[k] = LIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                lane_q[k]      <= LIdle;
                timer_q[k]     <= '0;
                res_valid_q[k] <= 1'b0;
                res_err_q[k]   <= 1'b0;
                res_data_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                lane_q[k]      <= lane_d[k];
                timer_q[k]     <= timer_d[k];
                res_valid_q[k] <= res_valid_d[k];
                res_err_q[k]   <= res_err_d[k];
                res_data_q[k]  <= res_data_d[k];
            end
        end
    end

    // ---------------- outputs ----------------
    assign t0_ready = lane_ready[0];
    assign t1_ready = lane_ready[1];
    assign sm_en0   = lane_xfer[0];
    assign sm_en1   = lane_xfer[1];

    // The phase gating makes the two transfers mutually exclusive; the priority is moot.
    always_comb begin
        sm_data_in = 2'b00;
        if (lane_xfer[0]) begin
            sm_data_in = t0_base;
        end else if (lane_xfer[1]) begin
            sm_data_in = t1_base;
        end
    end

    assign res0_valid = res_valid_q[0];
    assign res0_err   = res_err_q[0];
    assign res0_data  = res_data_q[0];
    assign res1_valid = res_valid_q[1];
    assign res1_err   = res_err_q[1];
    assign res1_data  = res_data_q[1];

    assign sm_ld_p          = ld_p_q;
    assign sm_ld_q          = ld_q_q;
    assign sm_match         = match_q;
    assign sm_mismatch      = mismatch_q;
    assign sm_gap_open      = gap_open_q;
    assign sm_gap_extend    = gap_extend_q;
    assign sm_query         = query_q;
    assign sm_output_select = out_sel_q;

endmodule

// File: tb/tb_sw_scoring_ctrl.sv
// Directed bench for sw_scoring_ctrl: configuration timing, phase-interleaved streaming
// (table driven), result capture/hold, timeout error and mid-stream reset.
module tb_sw_scoring_ctrl;

    localparam int SW      = 12;
    localparam int L       = 128;
    localparam int AW      = 8;
    localparam int TIMEOUT = 2 * L + 8;   // 264

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic [SW-1:0] cfg_match = '0, cfg_mismatch = '0, cfg_gap_open = '0, cfg_gap_extend = '0;
    logic [2*L-1:0] cfg_query = '0;
    logic [AW-1:0] cfg_qlen = '0;
    logic          cfg_busy;
    logic          t0_valid = 1'b0, t0_last = 1'b0, t1_valid = 1'b0, t1_last = 1'b0;
    logic [1:0]    t0_base = '0, t1_base = '0;
    logic          t0_ready, t1_ready;
    logic          res0_valid, res0_err, res1_valid, res1_err;
    logic [SW-1:0] res0_data, res1_data;
    logic          res0_ready = 1'b0, res1_ready = 1'b0;
    logic          sm_ld_p, sm_ld_q;
    logic [SW-1:0] sm_match, sm_mismatch, sm_gap_open, sm_gap_extend;
    logic [2*L-1:0] sm_query;
    logic [AW-1:0] sm_output_select;
    logic [1:0]    sm_data_in;
    logic          sm_en0, sm_en1;
    logic          sm_toggle = 1'b0, sm_vld0 = 1'b0, sm_vld1 = 1'b0;
    logic [SW-1:0] sm_result0 = '0, sm_result1 = '0;

    sw_scoring_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch),
        .cfg_gap_open(cfg_gap_open), .cfg_gap_extend(cfg_gap_extend),
        .cfg_query(cfg_query), .cfg_qlen(cfg_qlen), .cfg_busy(cfg_busy),
        .t0_valid(t0_valid), .t0_last(t0_last), .t0_base(t0_base), .t0_ready(t0_ready),
        .t1_valid(t1_valid), .t1_last(t1_last), .t1_base(t1_base), .t1_ready(t1_ready),
        .res0_valid(res0_valid), .res0_data(res0_data), .res0_err(res0_err),
        .res0_ready(res0_ready),
        .res1_valid(res1_valid), .res1_data(res1_data), .res1_err(res1_err),
        .res1_ready(res1_ready),
        .sm_ld_p(sm_ld_p), .sm_ld_q(sm_ld_q), .sm_match(sm_match),
        .sm_mismatch(sm_mismatch), .sm_gap_open(sm_gap_open),
        .sm_gap_extend(sm_gap_extend), .sm_query(sm_query),
        .sm_output_select(sm_output_select), .sm_data_in(sm_data_in),
        .sm_en0(sm_en0), .sm_en1(sm_en1), .sm_toggle(sm_toggle),
        .sm_vld0(sm_vld0), .sm_vld1(sm_vld1),
        .sm_result0(sm_result0), .sm_result1(sm_result1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       tog;
        logic       v0;
        logic [1:0] b0;
        logic       v1;
        logic [1:0] b1;
        logic       r0;
        logic       r1;
        logic       e0;
        logic       e1;
        logic [1:0] d;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2*L-1:0] q;
        int wcnt;
        int k;

        //                tog  v0    b0     v1    b1     r0    r1    e0    e1    d
        tbl[0] = '{1'b0, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01};
        tbl[1] = '{1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10};
        tbl[2] = '{1'b0, 1'b1, 2'b10, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10};
        tbl[3] = '{1'b1, 1'b1, 2'b00, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11};
        tbl[4] = '{1'b0, 1'b0, 2'b11, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[5] = '{1'b1, 1'b1, 2'b01, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
        tbl[6] = '{1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11};
        tbl[7] = '{1'b1, 1'b0, 2'b10, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01};

        // ---- reset state ----
        step(); step(); step();
        chk("rst_busy", 32'(cfg_busy), 0);
        chk("rst_ld_p", 32'(sm_ld_p), 0);
        chk("rst_ld_q", 32'(sm_ld_q), 0);
        chk("rst_res0_valid", 32'(res0_valid), 0);
        chk("rst_res1_valid", 32'(res1_valid), 0);
        chk("rst_t0_ready", 32'(t0_ready), 0);
        chk("rst_sel", 32'(sm_output_select), 0);

        // ---- configuration: cycle n ----
        rst = 1'b0;
        q = {8{32'hA5C3_1E0F}};
        q[31:0] = 32'h0123_4567;
        cfg_start = 1'b1; cfg_match = 12'd2; cfg_mismatch = 12'h7FE;
        cfg_gap_open = 12'h7FD; cfg_gap_extend = 12'h7FF; cfg_query = q; cfg_qlen = 8'd10;
        #1 chk("cfg_busy_n", 32'(cfg_busy), 0);
        step();   // n+1
        cfg_start = 1'b0;
        cfg_match = '0; cfg_mismatch = '0; cfg_gap_open = '0; cfg_gap_extend = '0;
        cfg_query = '0; cfg_qlen = '0;
        chk("ld_p_n1", 32'(sm_ld_p), 1);
        chk("ld_q_n1", 32'(sm_ld_q), 0);
        chk("busy_n1", 32'(cfg_busy), 1);
        chk("match", 32'(sm_match), 2);
        chk("mismatch", 32'(sm_mismatch), 32'h7FE);
        chk("gap_open", 32'(sm_gap_open), 32'h7FD);
        chk("gap_extend", 32'(sm_gap_extend), 32'h7FF);
        chk("out_sel", 32'(sm_output_select), 10);
        chk("query_lo", sm_query[31:0], q[31:0]);
        chk("query_hi", sm_query[255:224], q[255:224]);
        step();   // n+2
        chk("ld_p_n2", 32'(sm_ld_p), 0);
        chk("ld_q_n2", 32'(sm_ld_q), 1);
        for (int j = 3; j <= 18; j++) begin
            step();
            chk("prop_busy", 32'(cfg_busy), 1);
            chk("prop_t0_ready", 32'(t0_ready), 0);
            chk("prop_ld", 32'({sm_ld_p, sm_ld_q}), 0);
        end
        step();   // n+19: RUN
        chk("run_busy", 32'(cfg_busy), 0);
        chk("run_t0_ready_tog0", 32'(t0_ready), 1);
        chk("run_t1_ready_tog0", 32'(t1_ready), 0);
        sm_toggle = 1'b1;
        #1;
        chk("run_t0_ready_tog1", 32'(t0_ready), 0);
        chk("run_t1_ready_tog1", 32'(t1_ready), 1);

        // ---- interleaved streaming, no last ----
        for (int i = 0; i < 8; i++) begin
            sm_toggle = tbl[i].tog;
            t0_valid = tbl[i].v0; t0_base = tbl[i].b0;
            t1_valid = tbl[i].v1; t1_base = tbl[i].b1;
            #1;
            chk($sformatf("tbl%0d_t0_ready", i), 32'(t0_ready), 32'(tbl[i].r0));
            chk($sformatf("tbl%0d_t1_ready", i), 32'(t1_ready), 32'(tbl[i].r1));
            chk($sformatf("tbl%0d_en0", i), 32'(sm_en0), 32'(tbl[i].e0));
            chk($sformatf("tbl%0d_en1", i), 32'(sm_en1), 32'(tbl[i].e1));
            chk($sformatf("tbl%0d_data", i), 32'(sm_data_in), 32'(tbl[i].d));
            step();
        end
        t1_valid = 1'b0;

        // ---- lane 0: 4th base carries last, then array result ----
        sm_toggle = 1'b0; t0_valid = 1'b1; t0_base = 2'b00; t0_last = 1'b1;
        #1;
        chk("last0_en0", 32'(sm_en0), 1);
        chk("busy_feeding", 32'(cfg_busy), 1);
        step();
        t0_valid = 1'b0; t0_last = 1'b0;
        #1 chk("wait0_t0_ready", 32'(t0_ready), 0);
        sm_vld0 = 1'b1; sm_result0 = 12'h80A;
        #1 chk("vld0_same_cycle", 32'(res0_valid), 0);
        step();
        sm_vld0 = 1'b0; sm_result0 = 12'h000;
        chk("res0_valid", 32'(res0_valid), 1);
        chk("res0_data", 32'(res0_data), 32'h80A);
        chk("res0_err", 32'(res0_err), 0);

        // ---- hold res0 for 20 cycles while lane 1 streams; cfg_start ignored ----
        res0_ready = 1'b0;
        cfg_start = 1'b1; cfg_qlen = 8'd33;
        for (int i = 0; i < 20; i++) begin
            sm_toggle = 1'(i);
            t1_valid = 1'(i); t1_base = 2'((i >> 1) & 3); t1_last = (i == 19);
            t0_valid = 1'b1;
            #1;
            chk("hold_res0_valid", 32'(res0_valid), 1);
            chk("hold_res0_data", 32'(res0_data), 32'h80A);
            chk("hold_t0_ready", 32'(t0_ready), 0);
            chk("hold_busy", 32'(cfg_busy), 1);
            chk("hold_ld_p", 32'(sm_ld_p), 0);
            chk("hold_en1", 32'(sm_en1), 32'(i % 2));
            chk("hold_en0", 32'(sm_en0), 0);
            if ((i % 2) == 1) chk("hold_data1", 32'(sm_data_in), 32'((i >> 1) & 3));
            step();
        end
        cfg_start = 1'b0; cfg_qlen = '0;
        t0_valid = 1'b0; t1_valid = 1'b0; t1_last = 1'b0;
        wcnt = 1;
        chk("hold_sel_kept", 32'(sm_output_select), 10);

        res0_ready = 1'b1;
        step(); wcnt++;
        res0_ready = 1'b0;
        chk("res0_consumed_valid", 32'(res0_valid), 0);
        chk("res0_consumed_err", 32'(res0_err), 0);
        sm_toggle = 1'b0;
        #1 chk("t0_ready_after_consume", 32'(t0_ready), 1);
        // stray result pulse while lane 0 is idle
        sm_vld0 = 1'b1; sm_result0 = 12'h123;
        step(); wcnt++;
        sm_vld0 = 1'b0; sm_result0 = 12'h000;
        chk("stray_vld0_ignored", 32'(res0_valid), 0);

        // ---- lane 1 timeout ----
        while (!res1_valid && wcnt < TIMEOUT + 10) begin
            step(); wcnt++;
        end
        chk("timeout_not_early", 32'(wcnt >= TIMEOUT), 1);
        chk("timeout_not_late", 32'(wcnt <= TIMEOUT + 3), 1);
        chk("timeout_valid", 32'(res1_valid), 1);
        chk("timeout_err", 32'(res1_err), 1);
        chk("timeout_data", 32'(res1_data), 0);
        res1_ready = 1'b1;
        step();
        res1_ready = 1'b0;
        chk("res1_consumed_valid", 32'(res1_valid), 0);
        chk("res1_consumed_err", 32'(res1_err), 0);
        chk("idle_busy", 32'(cfg_busy), 0);

        // ---- reconfiguration from RUN ----
        cfg_start = 1'b1; cfg_qlen = 8'd7; cfg_match = 12'd3;
        step();
        cfg_start = 1'b0;
        chk("reconf_ld_p", 32'(sm_ld_p), 1);
        chk("reconf_sel", 32'(sm_output_select), 7);
        chk("reconf_match", 32'(sm_match), 3);
        k = 1;
        while (cfg_busy && k < 40) begin
            step(); k++;
        end
        chk("reconf_run_cycle", 32'(k), 19);

        // ---- reset during lane 0 feed ----
        sm_toggle = 1'b0; t0_valid = 1'b1; t0_base = 2'b01; t0_last = 1'b0;
        #1 chk("feed_en0", 32'(sm_en0), 1);
        step();
        t0_valid = 1'b0;
        chk("feed_busy", 32'(cfg_busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(cfg_busy), 0);
        chk("mid_rst_t0_ready", 32'(t0_ready), 0);
        chk("mid_rst_res0_valid", 32'(res0_valid), 0);
        chk("mid_rst_res1_valid", 32'(res1_valid), 0);
        chk("mid_rst_res0_data", 32'(res0_data), 0);
        chk("mid_rst_ld", 32'({sm_ld_p, sm_ld_q}), 0);
        chk("mid_rst_match", 32'(sm_match), 0);
        step();
        chk("mid_rst_stays_idle", 32'(t0_ready), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
